// File: rtl/dmem_bridge.sv
// Data-memory bridge: load/store stage to a single-outstanding req/ack bus with lane steering.
// Optional misalignment trap is enabled by defining MISALIGN_CHECK_EN.
module dmem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_err,
  output logic        o_req,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [3:0]  o_be,
  output logic [31:0] o_bwdata,
  input  logic        i_ack,
  input  logic [31:0] i_brdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_next;
  logic          is_load, is_store, is_mem, f3_ok, misalign, go_bus, timeout_hit;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [3:0]    be_new;
  logic [31:0]   bwdata_new, rdata_new;

  // Decode the incoming access; unsupported size codes never reach the bus.
  always_comb begin
    is_load  = (i_op == OP_LOAD);
    is_store = (i_op == OP_STORE);
    is_mem   = is_load | is_store;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_load;
      default:                f3_ok = 1'b0;
    endcase
`ifdef MISALIGN_CHECK_EN
    misalign = f3_ok && (((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                         ((i_funct3 == 3'b010) && (i_addr[1:0] != 2'b00)));
`else
    misalign = 1'b0;
`endif
    go_bus = f3_ok && !misalign;
  end

  always_comb begin
    be_new     = 4'b1111;
    bwdata_new = '0;
    if (is_store) begin
      bwdata_new = i_wdata;
      case (i_funct3[1:0])
        2'b00: begin
          be_new     = 4'b0001 << i_addr[1:0];
          bwdata_new = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          be_new     = 4'b0011 << {i_addr[1], 1'b0};
          bwdata_new = {2{i_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Right-justify the addressed byte/half; vacated upper bits fill with zero.
  always_comb begin
    case (f3_q)
      3'b000, 3'b100: rdata_new = i_brdata >> {off_q, 3'b000};
      3'b001, 3'b101: rdata_new = i_brdata >> {off_q[1], 4'b0000};
      default:        rdata_new = i_brdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_comb begin
    state_next = state;
    o_stall    = 1'b0;
    o_req      = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          o_stall    = 1'b1;
          state_next = go_bus ? REQ : DONE;
        end
      end
      REQ: begin
        o_req   = 1'b1;
        o_stall = 1'b1;
        if (i_ack || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      o_we     <= 1'b0;
      o_addr   <= '0;
      o_be     <= '0;
      o_bwdata <= '0;
      o_rdata  <= '0;
      o_err    <= 1'b0;
      cnt      <= '0;
      f3_q     <= '0;
      off_q    <= '0;
    end else begin
      state <= state_next;
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem) begin
            f3_q    <= i_funct3;
            off_q   <= i_addr[1:0];
            cnt     <= '0;
            o_rdata <= '0;
            if (go_bus) begin
              o_we     <= is_store;
              o_addr   <= {i_addr[31:2], 2'b00};
              o_be     <= be_new;
              o_bwdata <= bwdata_new;
            end else begin
              o_we  <= 1'b0;
              o_err <= misalign;
            end
          end
        end
        REQ: begin
          // An ack in the final counted cycle takes priority over the timeout.
          if (i_ack) begin
            if (!o_we) o_rdata <= rdata_new;
          end else if (timeout_hit) begin
            o_err   <= 1'b1;
            o_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge, built with TIMEOUT = 4.
module tb_dmem_bridge;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  i_op;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, o_rdata, o_addr, o_bwdata, i_brdata;
  logic        o_stall, o_err, o_req, o_we, i_ack;
  logic [3:0]  o_be;

  int checks = 0;
  int fails  = 0;

  int          stalls, reqs, errc, done, stable;
  logic [31:0] rdata_done, req_addr, req_bwdata;
  logic [3:0]  req_be;
  logic        req_we;

  dmem_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .i_op(i_op), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_stall(o_stall), .o_err(o_err),
    .o_req(o_req), .o_we(o_we), .o_addr(o_addr), .o_be(o_be), .o_bwdata(o_bwdata),
    .i_ack(i_ack), .i_brdata(i_brdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one instruction until the pipeline is released, then samples the following IDLE cycle.
  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] brdata, input int ack_after);
    stalls = 0; reqs = 0; errc = 0; done = 0; stable = 1;
    rdata_done = 'x; req_addr = 'x; req_be = 'x; req_bwdata = 'x; req_we = 1'bx;
    i_op = op; i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_ack = 1'b0; i_brdata = brdata;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (o_req) begin
        if (reqs == 0) begin
          req_addr = o_addr; req_be = o_be; req_bwdata = o_bwdata; req_we = o_we;
        end else if (o_addr !== req_addr || o_be !== req_be || o_bwdata !== req_bwdata || o_we !== req_we) begin
          stable = 0;
        end
        reqs++;
      end
      if (o_err) errc++;
      if (o_stall) begin
        stalls++;
        i_ack = o_req && (ack_after >= 0) && (reqs - 1 == ack_after);
      end else begin
        rdata_done = o_rdata;
        i_op = 7'd0;
        i_ack = 1'b0;
        done = 1;
      end
      @(posedge clk); #1;
      if (done != 0) break;
    end
    #2;
    if (o_err) errc++;
    check_output("access_released", done, 1);
  endtask

  initial begin
    rst = 1'b1; i_op = 7'd0; i_funct3 = 3'd0; i_addr = '0; i_wdata = '0; i_ack = 1'b0; i_brdata = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #2;
    check_output("rst_req", o_req, 0);
    check_output("rst_we", o_we, 0);
    check_output("rst_addr", o_addr, 0);
    check_output("rst_be", o_be, 0);
    check_output("rst_bwdata", o_bwdata, 0);
    check_output("rst_rdata", o_rdata, 0);
    check_output("rst_err", o_err, 0);
    check_output("rst_stall", o_stall, 0);

    // sb to 0x1003, ack in first REQ cycle
    apply_stimulus(OP_STORE, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
    check_output("sb_addr", req_addr, 32'h0000_1000);
    check_output("sb_be", req_be, 4'b1000);
    check_output("sb_bwdata", req_bwdata, 32'hA5A5_A5A5);
    check_output("sb_we", req_we, 1);
    check_output("sb_stall", stalls, 2);
    check_output("sb_reqs", reqs, 1);

    // sh to 0x1002
    apply_stimulus(OP_STORE, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 0);
    check_output("sh_be", req_be, 4'b1100);
    check_output("sh_bwdata", req_bwdata, 32'hBEEF_BEEF);

    // lh from 0x2002, ack after 3 wait cycles
    apply_stimulus(OP_LOAD, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 3);
    check_output("lh_rdata", rdata_done, 32'h0000_8001);
    check_output("lh_stall", stalls, 5);
    check_output("lh_addr", req_addr, 32'h0000_2000);
    check_output("lh_be", req_be, 4'b1111);
    check_output("lh_we", req_we, 0);
    check_output("lh_stable", stable, 1);
    check_output("lh_err", errc, 0);

    // lb from byte 2, one wait cycle
    apply_stimulus(OP_LOAD, 3'b000, 32'h0000_1002, 32'h0, 32'h1122_3344, 1);
    check_output("lb_rdata", rdata_done, 32'h0000_1122);
    check_output("lb_stall", stalls, 3);

    // lw with no ack: timeout after 4 REQ cycles
    apply_stimulus(OP_LOAD, 3'b010, 32'h0000_4000, 32'h0, 32'hFFFF_FFFF, -1);
    check_output("to_reqs", reqs, 4);
    check_output("to_err_pulse", errc, 1);
    check_output("to_rdata", rdata_done, 0);
    check_output("to_stall", stalls, 5);

    // Back-to-back sw then lbu
    apply_stimulus(OP_STORE, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h0, 0);
    check_output("b2b_sw_reqs", reqs, 1);
    check_output("b2b_sw_we", req_we, 1);
    check_output("b2b_sw_be", req_be, 4'b1111);
    check_output("b2b_sw_bwdata", req_bwdata, 32'h1234_5678);
    apply_stimulus(OP_LOAD, 3'b100, 32'h0000_0011, 32'h0, 32'h0000_CC00, 0);
    check_output("b2b_lbu_reqs", reqs, 1);
    check_output("b2b_lbu_we", req_we, 0);
    check_output("b2b_lbu_addr", req_addr, 32'h0000_0010);
    check_output("b2b_lbu_rdata", rdata_done, 32'h0000_00CC);

    // Unsupported funct3: no bus access
    apply_stimulus(OP_LOAD, 3'b011, 32'h0000_0020, 32'h0, 32'hDEAD_0000, 0);
    check_output("bad_f3_reqs", reqs, 0);
    check_output("bad_f3_stall", stalls, 1);
    check_output("bad_f3_rdata", rdata_done, 0);
    check_output("bad_f3_err", errc, 0);

    // Reset in the middle of a store's REQ phase
    i_op = OP_STORE; i_funct3 = 3'b000; i_addr = 32'h0000_0041; i_wdata = 32'h11; i_ack = 1'b0;
    @(posedge clk); #3;
    check_output("mid_req_on", o_req, 1);
    rst = 1'b1; i_op = 7'd0;
    @(posedge clk); #1; rst = 1'b0; #2;
    check_output("mid_rst_req", o_req, 0);
    check_output("mid_rst_be", o_be, 0);
    check_output("mid_rst_stall", o_stall, 0);
    i_ack = 1'b1;
    @(posedge clk); #3;
    check_output("mid_late_ack_req", o_req, 0);
    check_output("mid_late_ack_err", o_err, 0);
    @(posedge clk); #1; i_ack = 1'b0; #2;
    check_output("mid_late_ack_err2", o_err, 0);
    apply_stimulus(OP_LOAD, 3'b010, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 0);
    check_output("post_rst_lw_rdata", rdata_done, 32'hCAFE_F00D);
    check_output("post_rst_lw_reqs", reqs, 1);

    // Misaligned sw to 0x3001
    apply_stimulus(OP_STORE, 3'b010, 32'h0000_3001, 32'hDEAD_BEEF, 32'h0, 0);
`ifdef MISALIGN_CHECK_EN
    check_output("mis_reqs", reqs, 0);
    check_output("mis_err", errc, 1);
    check_output("mis_stall", stalls, 1);
    check_output("mis_rdata", rdata_done, 0);
`else
    check_output("mis_reqs", reqs, 1);
    check_output("mis_addr", req_addr, 32'h0000_3000);
    check_output("mis_be", req_be, 4'b1111);
    check_output("mis_bwdata", req_bwdata, 32'hDEAD_BEEF);
    check_output("mis_err", errc, 0);
    check_output("mis_stall", stalls, 2);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
